// File: rtl/snn_frame_sequencer.sv
// Frame sequencer for the SNN core: synchronises input_ready/cfg_ready, issues one frame of
// timestep enables per input_ready rising edge, and accumulates saturating output spike counts.
module snn_frame_sequencer #(
    parameter int N_IN        = 24,
    parameter int N_OUT       = 2,
    parameter int CNT_W       = 8,
    parameter int STEPS_W     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DRAIN_MAX   = 16
) (
    input  logic                   system_clock,
    input  logic                   reset,
    input  logic                   input_ready,
    input  logic                   cfg_ready,
    input  logic [N_IN-1:0]        spikes_in,
    input  logic [STEPS_W-1:0]     num_steps,
    input  logic                   snn_out_valid,
    input  logic [N_OUT-1:0]       snn_output_spikes,
    output logic                   snn_enable,
    output logic [N_IN-1:0]        snn_spikes,
    output logic [N_OUT*CNT_W-1:0] spike_counts,
    output logic [N_OUT-1:0]       overflow,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_abort
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] ir_sync_q, cr_sync_q;
    logic ir_s, cr_s, ir_d_q, start_s;
    logic [1:0] state_q, state_d;
    logic [STEPS_W-1:0] steps_q, steps_d, step_cnt_q, step_cnt_d, valid_cnt_q, valid_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic enable_q, enable_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d;
    logic [N_IN-1:0] spikes_q, spikes_d;
    logic [N_OUT*CNT_W-1:0] counts_q, counts_d, counts_acc_s;
    logic [N_OUT-1:0] ovf_q, ovf_d, ovf_acc_s;
    logic [STEPS_W-1:0] valid_acc_s;
    logic active_s, count_en_s, complete_s;

    assign ir_s    = ir_sync_q[SYNC_STAGES-1];
    assign cr_s    = cr_sync_q[SYNC_STAGES-1];
    assign start_s = ir_s & ~ir_d_q & cr_s;

    // Synchronisers and input_ready edge detector; the edge flop runs in every state so
    // edges seen outside IDLE are consumed rather than queued.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            ir_sync_q <= '0;
            cr_sync_q <= '0;
            ir_d_q    <= 1'b0;
        end else begin
            ir_sync_q <= {ir_sync_q[SYNC_STAGES-2:0], input_ready};
            cr_sync_q <= {cr_sync_q[SYNC_STAGES-2:0], cfg_ready};
            ir_d_q    <= ir_s;
        end
    end

    assign active_s   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign count_en_s = active_s && snn_out_valid && (valid_cnt_q != steps_q);

    // Saturating per-channel spike accumulation for this cycle's SNN result.
    always_comb begin
        counts_acc_s = counts_q;
        ovf_acc_s    = ovf_q;
        valid_acc_s  = valid_cnt_q;
        if (count_en_s) begin
            valid_acc_s = valid_cnt_q + STEPS_W'(1);
            for (int i = 0; i < N_OUT; i++) begin
                if (!snn_output_spikes[i]) begin
                    counts_acc_s[i*CNT_W +: CNT_W] = counts_q[i*CNT_W +: CNT_W];
                end else if (counts_q[i*CNT_W +: CNT_W] == CNT_MAX) begin
                    ovf_acc_s[i] = 1'b1;
                end else begin
                    counts_acc_s[i*CNT_W +: CNT_W] = counts_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end else begin
            valid_acc_s = valid_cnt_q;
        end
    end

    assign complete_s = active_s && (valid_acc_s == steps_q);

    // Frame state machine; cfg_ready loss outranks completion, completion outranks drain timeout.
    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        step_cnt_d  = step_cnt_q;
        valid_cnt_d = valid_cnt_q;
        drain_cnt_d = drain_cnt_q;
        spikes_d    = spikes_q;
        counts_d    = counts_q;
        ovf_d       = ovf_q;
        enable_d    = 1'b0;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    spikes_d    = spikes_in;
                    steps_d     = num_steps;
                    counts_d    = '0;
                    ovf_d       = '0;
                    valid_cnt_d = '0;
                    drain_cnt_d = '0;
                    if (num_steps != '0) begin
                        state_d    = S_RUN;
                        step_cnt_d = STEPS_W'(1);
                        enable_d   = 1'b1;
                    end else begin
                        state_d    = S_DONE;
                        step_cnt_d = '0;
                        done_d     = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN, S_DRAIN: begin
                counts_d    = counts_acc_s;
                ovf_d       = ovf_acc_s;
                valid_cnt_d = valid_acc_s;
                if (!cr_s || (state_q == S_DRAIN && !complete_s &&
                              drain_cnt_q == DW'(DRAIN_MAX - 1))) begin
                    state_d  = S_IDLE;
                    counts_d = '0;
                    ovf_d    = '0;
                    abort_d  = 1'b1;
                end else if (complete_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (state_q == S_DRAIN) begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end else if (step_cnt_q == steps_q) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt_q + STEPS_W'(1);
                    enable_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    // Frame state and registered outputs.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            steps_q     <= '0;
            step_cnt_q  <= '0;
            valid_cnt_q <= '0;
            drain_cnt_q <= '0;
            spikes_q    <= '0;
            counts_q    <= '0;
            ovf_q       <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            steps_q     <= steps_d;
            step_cnt_q  <= step_cnt_d;
            valid_cnt_q <= valid_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            spikes_q    <= spikes_d;
            counts_q    <= counts_d;
            ovf_q       <= ovf_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign snn_enable   = enable_q;
    assign snn_spikes   = spikes_q;
    assign spike_counts = counts_q;
    assign overflow     = ovf_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
endmodule

// File: tb/tb_snn_frame_sequencer.sv
// Bench for snn_frame_sequencer (CNT_W=2 so saturation is reachable): frame vector table,
// SNN responder with 1-cycle latency, and an expected-result queue popped on done/abort.
module tb_snn_frame_sequencer;
    localparam int N_IN = 24, N_OUT = 2, CNT_W = 2, STEPS_W = 8, SYNC = 2, DMAX = 16;

    logic system_clock = 1'b0;
    logic reset, input_ready, cfg_ready, snn_out_valid;
    logic [N_IN-1:0] spikes_in;
    logic [STEPS_W-1:0] num_steps;
    logic [N_OUT-1:0] snn_output_spikes;
    logic snn_enable, busy, frame_done, frame_abort;
    logic [N_IN-1:0] snn_spikes;
    logic [N_OUT*CNT_W-1:0] spike_counts;
    logic [N_OUT-1:0] overflow;

    snn_frame_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .STEPS_W(STEPS_W),
                          .SYNC_STAGES(SYNC), .DRAIN_MAX(DMAX)) dut (
        .system_clock(system_clock), .reset(reset), .input_ready(input_ready),
        .cfg_ready(cfg_ready), .spikes_in(spikes_in), .num_steps(num_steps),
        .snn_out_valid(snn_out_valid), .snn_output_spikes(snn_output_spikes),
        .snn_enable(snn_enable), .snn_spikes(snn_spikes), .spike_counts(spike_counts),
        .overflow(overflow), .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #5 system_clock = ~system_clock;

    typedef struct {
        logic [7:0]  steps;
        logic [23:0] spk;
        logic [15:0] m0;
        logic [15:0] m1;
        bit          resp;
        int          drop_at;
        bit          reedge;
        int          exp_en;
        int          exp_drain;
        bit          exp_done;
        bit          exp_abort;
        logic [3:0]  exp_cnt;
        logic [1:0]  exp_ov;
    } vec_t;

    vec_t vecs[7];
    vec_t sb[$];
    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        input_ready = 1'b0;
        cfg_ready = 1'b1;
        snn_out_valid = 1'b0;
        snn_output_spikes = '0;
        repeat (n) @(posedge system_clock);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int en_cnt = 0, drain = 0, dn = 0, ab = 0, vidx = 0;
        bit prev_en = 1'b0;
        vec_t e;
        num_steps = v.steps;
        spikes_in = v.spk;
        sb.push_back(v);
        input_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge system_clock);
            #1;
            if (snn_enable) begin
                en_cnt++;
                if (en_cnt == 1) chk($sformatf("v%0d snn_spikes", idx), 64'(snn_spikes), 64'(v.spk));
            end
            if (busy && !snn_enable) drain++;
            if (frame_done) dn++;
            if (frame_abort) ab++;
            if (frame_done || frame_abort) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d pulse_kind", idx), {62'd0, frame_done, frame_abort},
                        {62'd0, e.exp_done, e.exp_abort});
                    chk($sformatf("v%0d counts", idx), 64'(spike_counts), 64'(e.exp_cnt));
                    chk($sformatf("v%0d overflow", idx), 64'(overflow), 64'(e.exp_ov));
                end else begin
                    chk($sformatf("v%0d unexpected_pulse", idx), 64'd1, 64'd0);
                end
            end
            snn_out_valid = prev_en & v.resp;
            snn_output_spikes = '0;
            if (prev_en && vidx < 16) begin
                snn_output_spikes = {v.m1[vidx], v.m0[vidx]};
                vidx++;
            end
            prev_en = snn_enable;
            if (v.drop_at != 0 && en_cnt == v.drop_at) cfg_ready = 1'b0;
            if (v.reedge && en_cnt == 1) input_ready = 1'b0;
            if (v.reedge && en_cnt == 3) input_ready = 1'b1;
        end
        chk($sformatf("v%0d queue_drained", idx), 64'(sb.size()), 64'd0);
        sb.delete();
        chk($sformatf("v%0d enable_cycles", idx), 64'(en_cnt), 64'(v.exp_en));
        chk($sformatf("v%0d drain_cycles", idx), 64'(drain), 64'(v.exp_drain));
        chk($sformatf("v%0d done_pulses", idx), 64'(dn), 64'(v.exp_done));
        chk($sformatf("v%0d abort_pulses", idx), 64'(ab), 64'(v.exp_abort));
        idle(6);
    endtask

    initial begin
        bit seen;
        //          steps  spikes        m0        m1        rsp  drop re  en drn dn   ab   cnt    ov
        vecs[0] = '{8'd4, 24'hA5A5A5, 16'h0007, 16'h0000, 1'b1, 0, 1'b0, 4, 1, 1'b1, 1'b0, 4'h3, 2'b00};
        vecs[1] = '{8'd6, 24'h123456, 16'h003F, 16'h0015, 1'b1, 0, 1'b0, 6, 1, 1'b1, 1'b0, 4'hF, 2'b01};
        vecs[2] = '{8'd8, 24'h0F0F0F, 16'h00FF, 16'h00FF, 1'b1, 2, 1'b0, 4, 0, 1'b0, 1'b1, 4'h0, 2'b00};
        vecs[3] = '{8'd3, 24'h00FF00, 16'h0007, 16'h0007, 1'b0, 0, 1'b0, 3, DMAX, 1'b0, 1'b1, 4'h0, 2'b00};
        vecs[4] = '{8'd0, 24'hFFFFFF, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 0, 0, 1'b1, 1'b0, 4'h0, 2'b00};
        vecs[5] = '{8'd5, 24'h5A5A5A, 16'h001B, 16'h0006, 1'b1, 0, 1'b1, 5, 1, 1'b1, 1'b0, 4'hB, 2'b01};
        vecs[6] = '{8'd1, 24'h000001, 16'h0000, 16'h0001, 1'b1, 0, 1'b0, 1, 1, 1'b1, 1'b0, 4'h4, 2'b00};

        reset = 1'b1;
        input_ready = 1'b0;
        cfg_ready = 1'b0;
        spikes_in = '0;
        num_steps = '0;
        snn_out_valid = 1'b0;
        snn_output_spikes = '0;
        repeat (3) @(posedge system_clock);
        #1;
        chk("reset_outputs", {30'd0, snn_enable, busy, frame_done, frame_abort, overflow,
                              spike_counts, snn_spikes}, 64'd0);
        reset = 1'b0;
        idle(6);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset while the frame is waiting in DRAIN for results that never come.
        num_steps = 8'd3;
        spikes_in = 24'hA5A5A5;
        input_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge system_clock);
            #1;
            if (busy && !snn_enable) seen = 1'b1;
        end
        chk("reach_drain", 64'(seen), 64'd1);
        repeat (3) @(posedge system_clock);
        #3;
        reset = 1'b1;
        #1;
        chk("reset_mid_drain", {30'd0, snn_enable, busy, frame_done, frame_abort, overflow,
                                spike_counts, snn_spikes}, 64'd0);
        repeat (2) @(posedge system_clock);
        #1;
        input_ready = 1'b0;
        reset = 1'b0;
        idle(6);
        run_vec(7, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
